// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory stage.
//   - widths of the register-file address/data and memory-operator buses
//   - memory operator encodings (anything outside 0..8 behaves as NONE)
//   - bus byte-select constants (big-endian: bit 3 = byte 0 = bits 31:24)
//   - FSM state encoding and small operator classification helpers
package mem_stage_pkg;

  localparam int MEM_OPERATOR_BUS = 4;
  localparam int REGS_ADDR_BUS    = 5;
  localparam int REGS_DATA_BUS    = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_NONE = 4'd0;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_LB   = 4'd1;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_LBU  = 4'd2;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_LH   = 4'd3;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_LHU  = 4'd4;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_LW   = 4'd5;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_SB   = 4'd6;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_SH   = 4'd7;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_SW   = 4'd8;

  localparam logic [3:0] BSEL_BYTE    = 4'b1000;  // shifted right by addr[1:0]
  localparam logic [3:0] BSEL_HALF_HI = 4'b1100;
  localparam logic [3:0] BSEL_HALF_LO = 4'b0011;
  localparam logic [3:0] BSEL_WORD    = 4'b1111;

  typedef enum logic {
    STATE_IDLE   = 1'b0,
    STATE_ACCESS = 1'b1
  } state_t;

  function automatic logic is_load(input logic [MEM_OPERATOR_BUS-1:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [MEM_OPERATOR_BUS-1:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_byte_op(input logic [MEM_OPERATOR_BUS-1:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_SB);
  endfunction

  function automatic logic is_half_op(input logic [MEM_OPERATOR_BUS-1:0] op);
    return (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
  endfunction

  function automatic logic is_word_op(input logic [MEM_OPERATOR_BUS-1:0] op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [MEM_OPERATOR_BUS-1:0] op,
                                         input logic [1:0] offset);
    return (is_half_op(op) && offset[0]) || (is_word_op(op) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data lane selection and extension.
// Ports:
//   read_data   in  32  raw word from the data bus (big-endian lanes)
//   byte_offset in  2   low address bits of the load
//   operator    in  4   memory operator of the load
//   load_value  out 32  selected lane, sign- or zero-extended
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [REGS_DATA_BUS-1:0]    read_data,
  input  logic [1:0]                  byte_offset,
  input  logic [MEM_OPERATOR_BUS-1:0] operator,
  output logic [REGS_DATA_BUS-1:0]    load_value
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane gi is byte address gi within the word; byte 0 is the MSB.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = read_data[31-8*gi -: 8];
  end

  assign byte_sel = lane[byte_offset];
  assign half_sel = byte_offset[1] ? read_data[15:0] : read_data[31:16];

  always_comb begin
    load_value = '0;
    case (operator)
      MEM_LB:  load_value = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: load_value = {24'd0, byte_sel};
      MEM_LH:  load_value = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: load_value = {16'd0, half_sel};
      MEM_LW:  load_value = read_data;
      default: load_value = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory access stage and MEM/WB boundary register.
// Ports:
//   clock, reset (async, active-low)
//   input_write_addr/enable/data : execute result
//   mem_operator, mem_address, mem_store_data : load/store request
//   flush                        : discard the instruction in this stage
//   bus_request/write/address/byte_select/write_data : registered bus request
//   bus_read_data, bus_ack       : bus response (ack is a one-cycle strobe)
//   stall_request                : combinational upstream freeze
//   write_addr/enable/data       : registered writeback triple
//   misaligned_error, bus_timeout_error : one-cycle fault pulses
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [REGS_ADDR_BUS-1:0]    input_write_addr,
  input  logic                        input_write_enable,
  input  logic [REGS_DATA_BUS-1:0]    input_write_data,
  input  logic [MEM_OPERATOR_BUS-1:0] mem_operator,
  input  logic [31:0]                 mem_address,
  input  logic [31:0]                 mem_store_data,
  input  logic                        flush,
  output logic                        bus_request,
  output logic                        bus_write,
  output logic [31:0]                 bus_address,
  output logic [3:0]                  bus_byte_select,
  output logic [31:0]                 bus_write_data,
  input  logic [31:0]                 bus_read_data,
  input  logic                        bus_ack,
  output logic                        stall_request,
  output logic [REGS_ADDR_BUS-1:0]    write_addr,
  output logic                        write_enable,
  output logic [REGS_DATA_BUS-1:0]    write_data,
  output logic                        misaligned_error,
  output logic                        bus_timeout_error
);

  state_t                      state_reg, state_next;
  logic [7:0]                  counter_reg;
  logic                        pending_flush_reg;
  logic [MEM_OPERATOR_BUS-1:0] op_reg;
  logic [1:0]                  offset_reg;

  logic                        is_mem;
  logic                        misaligned;
  logic                        start_access;
  logic                        timeout_hit;
  logic [3:0]                  req_byte_select;
  logic [31:0]                 req_write_data;
  logic [REGS_DATA_BUS-1:0]    load_value;

  assign is_mem       = is_load(mem_operator) || is_store(mem_operator);
  assign misaligned   = is_misaligned(mem_operator, mem_address[1:0]);
  assign start_access = is_mem && !misaligned && !flush;
  // Counter starts at 0 on entry, so TIMEOUT_CYCLES ack-less cycles elapse.
  assign timeout_hit  = (counter_reg == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    req_byte_select = BSEL_WORD;
    if (is_byte_op(mem_operator)) begin
      req_byte_select = BSEL_BYTE >> mem_address[1:0];
    end else if (is_half_op(mem_operator)) begin
      req_byte_select = mem_address[1] ? BSEL_HALF_LO : BSEL_HALF_HI;
    end
  end

  // Store data is replicated so whichever lanes are selected carry it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
    assign req_write_data[31-8*gi -: 8] =
        is_byte_op(mem_operator) ? mem_store_data[7:0] :
        is_half_op(mem_operator) ? ((gi % 2 == 0) ? mem_store_data[15:8]
                                                  : mem_store_data[7:0]) :
        mem_store_data[31-8*gi -: 8];
  end

  mem_load_align u_load_align (
    .read_data   (bus_read_data),
    .byte_offset (offset_reg),
    .operator    (op_reg),
    .load_value  (load_value)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= STATE_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Stall drops in the ack/timeout cycle so upstream advances on that edge.
  always_comb begin
    state_next    = state_reg;
    stall_request = 1'b0;
    case (state_reg)
      STATE_IDLE: begin
        if (start_access) begin
          state_next    = STATE_ACCESS;
          stall_request = 1'b1;
        end
      end
      STATE_ACCESS: begin
        if (bus_ack || timeout_hit) begin
          state_next = STATE_IDLE;
        end else begin
          stall_request = 1'b1;
        end
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter_reg       <= '0;
      pending_flush_reg <= 1'b0;
      op_reg            <= MEM_NONE;
      offset_reg        <= '0;
      bus_request       <= 1'b0;
      bus_write         <= 1'b0;
      bus_address       <= '0;
      bus_byte_select   <= '0;
      bus_write_data    <= '0;
      write_addr        <= '0;
      write_enable      <= DISABLE;
      write_data        <= '0;
      misaligned_error  <= 1'b0;
      bus_timeout_error <= 1'b0;
    end else begin
      misaligned_error  <= 1'b0;
      bus_timeout_error <= 1'b0;
      case (state_reg)
        STATE_IDLE: begin
          pending_flush_reg <= 1'b0;
          if (flush) begin
            write_enable <= DISABLE;
          end else if (!is_mem) begin
            write_addr   <= input_write_addr;
            write_enable <= input_write_enable;
            write_data   <= input_write_data;
          end else if (misaligned) begin
            write_enable     <= DISABLE;
            misaligned_error <= 1'b1;
          end else begin
            bus_request     <= 1'b1;
            bus_write       <= is_store(mem_operator);
            bus_address     <= {mem_address[31:2], 2'b00};
            bus_byte_select <= req_byte_select;
            bus_write_data  <= req_write_data;
            counter_reg     <= '0;
            op_reg          <= mem_operator;
            offset_reg      <= mem_address[1:0];
            write_enable    <= DISABLE;
          end
        end
        STATE_ACCESS: begin
          if (bus_ack) begin
            bus_request       <= 1'b0;
            pending_flush_reg <= 1'b0;
            if (is_load(op_reg)) begin
              // A flush arriving in the ack cycle itself also discards.
              write_addr   <= input_write_addr;
              write_enable <= input_write_enable && !pending_flush_reg && !flush;
              write_data   <= load_value;
            end else begin
              write_enable <= DISABLE;
            end
          end else if (timeout_hit) begin
            bus_request       <= 1'b0;
            pending_flush_reg <= 1'b0;
            write_enable      <= DISABLE;
            bus_timeout_error <= 1'b1;
          end else begin
            counter_reg <= counter_reg + 8'd1;
            if (flush) begin
              pending_flush_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  input_write_addr;
  logic        input_write_enable;
  logic [31:0] input_write_data;
  logic [3:0]  mem_operator;
  logic [31:0] mem_address;
  logic [31:0] mem_store_data;
  logic        flush;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_select;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_ack;
  logic        stall_request;
  logic [4:0]  write_addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic        misaligned_error;
  logic        bus_timeout_error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clock              (clock),
    .reset              (reset),
    .input_write_addr   (input_write_addr),
    .input_write_enable (input_write_enable),
    .input_write_data   (input_write_data),
    .mem_operator       (mem_operator),
    .mem_address        (mem_address),
    .mem_store_data     (mem_store_data),
    .flush              (flush),
    .bus_request        (bus_request),
    .bus_write          (bus_write),
    .bus_address        (bus_address),
    .bus_byte_select    (bus_byte_select),
    .bus_write_data     (bus_write_data),
    .bus_read_data      (bus_read_data),
    .bus_ack            (bus_ack),
    .stall_request      (stall_request),
    .write_addr         (write_addr),
    .write_enable       (write_enable),
    .write_data         (write_data),
    .misaligned_error   (misaligned_error),
    .bus_timeout_error  (bus_timeout_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes (0 = no memory access).
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic bit op_signed(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd3);
  endfunction

  // Byte address i is lane i; lane i is bit (3-i) of the select.
  function automatic logic [3:0] exp_bsel(input logic [3:0] op, input logic [31:0] addr);
    logic [3:0] bs;
    int off, size;
    bs = 4'b0000;
    off = int'(addr[1:0]);
    size = op_size(op);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + size) bs[3-i] = 1'b1;
    return bs;
  endfunction

  function automatic logic [31:0] exp_store(input logic [3:0] op, input logic [31:0] sdata);
    logic [31:0] w;
    int size;
    size = op_size(op);
    w = 0;
    for (int i = 0; i < 4; i++)
      w = (w << 8) | ((sdata >> (8 * (size - 1 - (i % size)))) & 32'hFF);
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    longint v;
    int off, size;
    off = int'(addr[1:0]);
    size = op_size(op);
    v = 0;
    for (int i = 0; i < size; i++)
      v = v * 256 + longint'((rdata >> (24 - 8 * (off + i))) & 32'hFF);
    if (op_signed(op) && v >= (longint'(1) << (8 * size - 1)))
      v = v - (longint'(1) << (8 * size));
    return v[31:0];
  endfunction

  // One instruction through the stage. Entered and left at a falling edge.
  // ack_after: ACCESS cycle index (counter value) carrying bus_ack; -1 = never.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] wa,
                         input logic we, input logic [31:0] wd,
                         input int ack_after, input logic [31:0] rdata,
                         input bit flush_idle, input bit flush_access);
    int size;
    bit mem, mis, access, exp_we;
    size = op_size(op);
    mem = (size > 0);
    mis = mem && ((int'(addr[1:0]) % size) != 0);
    access = mem && !mis && !flush_idle;

    mem_operator = op; mem_address = addr; mem_store_data = sdata;
    input_write_addr = wa; input_write_enable = we; input_write_data = wd;
    flush = flush_idle; bus_ack = 1'b0; bus_read_data = $urandom;
    #1;
    chk("stall_start", stall_request, access);
    @(posedge clock); @(negedge clock);
    flush = 1'b0;

    if (!access) begin
      chk("no_bus_request", bus_request, 1'b0);
      chk("misaligned_error", misaligned_error, mem && mis && !flush_idle);
      exp_we = (mem || flush_idle) ? 1'b0 : we;
      chk("write_enable", write_enable, exp_we);
      if (!mem && !flush_idle) begin
        chk("pass_addr", write_addr, wa);
        chk("pass_data", write_data, wd);
      end
    end else begin
      for (int k = 0; k < TO; k++) begin
        chk("bus_request_held", bus_request, 1'b1);
        chk("bus_write", bus_write, op_store(op));
        chk("bus_address", bus_address, {addr[31:2], 2'b00});
        chk("bus_byte_select", bus_byte_select, exp_bsel(op, addr));
        if (op_store(op)) chk("bus_write_data", bus_write_data, exp_store(op, sdata));
        chk("we_during_access", write_enable, 1'b0);
        if (flush_access && k == 0) flush = 1'b1;
        if (k == ack_after) begin
          bus_ack = 1'b1; bus_read_data = rdata;
          #1 chk("stall_at_ack", stall_request, 1'b0);
          @(posedge clock); @(negedge clock);
          bus_ack = 1'b0; flush = 1'b0;
          chk("request_drop_ack", bus_request, 1'b0);
          chk("no_timeout_err", bus_timeout_error, 1'b0);
          exp_we = !op_store(op) && we && !flush_access;
          chk("we_after_ack", write_enable, exp_we);
          if (exp_we) begin
            chk("load_data", write_data, exp_load(op, addr, rdata));
            chk("load_addr", write_addr, wa);
          end
          break;
        end else if (k == TO - 1) begin
          #1 chk("stall_at_timeout", stall_request, 1'b0);
          @(posedge clock); @(negedge clock);
          flush = 1'b0;
          chk("request_drop_timeout", bus_request, 1'b0);
          chk("timeout_error", bus_timeout_error, 1'b1);
          chk("we_after_timeout", write_enable, 1'b0);
        end else begin
          #1 chk("stall_in_access", stall_request, 1'b1);
          @(posedge clock); @(negedge clock);
          flush = 1'b0;
        end
      end
    end

    // Idle bubble with a stray ack: must be ignored, error pulses must end.
    mem_operator = 4'd0; input_write_enable = 1'b0; bus_ack = 1'b1;
    #1 chk("stall_idle_ack", stall_request, 1'b0);
    @(posedge clock); @(negedge clock);
    bus_ack = 1'b0;
    chk("idle_request", bus_request, 1'b0);
    chk("misaligned_pulse_end", misaligned_error, 1'b0);
    chk("timeout_pulse_end", bus_timeout_error, 1'b0);
    chk("idle_we", write_enable, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    input_write_addr = '0; input_write_enable = 1'b0; input_write_data = '0;
    mem_operator = '0; mem_address = '0; mem_store_data = '0; flush = 1'b0;
    bus_read_data = '0; bus_ack = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_bus_request", bus_request, 1'b0);
    chk("rst_bus_address", bus_address, 32'h0);
    chk("rst_write_enable", write_enable, 1'b0);
    chk("rst_write_data", write_data, 32'h0);
    chk("rst_misaligned", misaligned_error, 1'b0);
    chk("rst_timeout", bus_timeout_error, 1'b0);
    reset = 1'b1;

    run_txn(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234_5678, -1, 32'h0, 0, 0);
    run_txn(4'd1, 32'h0000_0101, 32'h0, 5'd7, 1'b1, 32'h0, 3, 32'h11F2_3344, 0, 0);
    run_txn(4'd2, 32'h0000_0101, 32'h0, 5'd7, 1'b1, 32'h0, 3, 32'h11F2_3344, 0, 0);
    run_txn(4'd7, 32'h0000_0012, 32'hAAAA_BEEF, 5'd3, 1'b1, 32'h0, 1, 32'h0, 0, 0);
    run_txn(4'd5, 32'h0000_0006, 32'h0, 5'd4, 1'b1, 32'h0, 0, 32'h0, 0, 0);
    run_txn(4'd5, 32'h0000_0020, 32'h0, 5'd9, 1'b1, 32'h0, -1, 32'h0, 0, 0);
    run_txn(4'd5, 32'h0000_0040, 32'h0, 5'd9, 1'b1, 32'h0, 2, 32'hCAFE_F00D, 0, 1);
    run_txn(4'd5, 32'h0000_0044, 32'h0, 5'd9, 1'b1, 32'h0, 0, 32'h1, 1, 0);
    run_txn(4'd3, 32'h0000_0002, 32'h0, 5'd1, 1'b1, 32'h0, 0, 32'h1234_8765, 0, 0);

    // Asynchronous reset in the middle of an access.
    mem_operator = 4'd5; mem_address = 32'h0000_0100; input_write_enable = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("pre_reset_request", bus_request, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_request", bus_request, 1'b0);
    chk("async_rst_address", bus_address, 32'h0);
    chk("async_rst_bsel", bus_byte_select, 4'h0);
    chk("async_rst_we", write_enable, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    run_txn(4'd0, 32'h0, 32'h0, 5'd12, 1'b1, 32'hDEAD_BEEF, -1, 32'h0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [3:0]  r_op;
      logic [31:0] r_addr, r_sdata, r_wd, r_rd;
      logic [4:0]  r_wa;
      logic        r_we;
      int          r_ack;
      bit          r_fi, r_fa;
      r_op = 4'($urandom_range(0, 15));
      r_addr = $urandom; r_sdata = $urandom; r_wd = $urandom; r_rd = $urandom;
      r_wa = 5'($urandom_range(0, 31));
      r_we = 1'($urandom_range(0, 1));
      r_ack = $urandom_range(0, TO);
      r_fi = ($urandom_range(0, 7) == 0);
      r_fa = ($urandom_range(0, 5) == 0);
      run_txn(r_op, r_addr, r_sdata, r_wa, r_we, r_wd, r_ack, r_rd, r_fi, r_fa);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
